// File: rtl/spart_if.sv
// Processor-side bus bundle for the SPART: chip select, direction, address
// and the two handshake flags reported back to the driver.
interface spart_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (output iocs, iorw, ioaddr, input rda, tbr);
   modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart.sv
// SPART: 8N1 serial port with a 16x fractional baud generator, one-byte
// TX/RX buffers and a tri-stated 8-bit register interface.
module spart #(
   parameter int ACC_W = 22
) (
   input  logic       clk,
   input  logic       rst,
   spart_if.slave     bus,
   inout  wire  [7:0] databus,
   output logic       txd,
   input  logic       rxd
);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   logic [15:0]      db;
   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   acc_sum;
   logic             tick;

   logic wr_data, rd_data, rd_stat, drive;
   logic [7:0] status, rdata;

   logic [7:0] tx_buf;
   logic       tbr_q, tx_take;
   tx_state_t  tx_state, tx_state_n;
   logic [3:0] tx_cnt, tx_cnt_n;
   logic [2:0] tx_bit, tx_bit_n;
   logic [7:0] tx_sh, tx_sh_n;
   logic       txd_n;

   logic       rx_s1, rxs;
   rx_state_t  rx_state, rx_state_n;
   logic [3:0] rx_cnt, rx_cnt_n;
   logic [2:0] rx_bit, rx_bit_n;
   logic [7:0] rx_sh, rx_sh_n;
   logic       rx_ok, rx_bad;
   logic [7:0] rx_buf;
   logic       rda_q, ferr_q, ovr_q;

   // Bus decode and combinational read mux
   assign wr_data = bus.iocs & ~bus.iorw & (bus.ioaddr == 2'b00);
   assign rd_data = bus.iocs &  bus.iorw & (bus.ioaddr == 2'b00);
   assign rd_stat = bus.iocs &  bus.iorw & (bus.ioaddr == 2'b01);
   assign drive   = bus.iocs &  bus.iorw & ~bus.ioaddr[1];
   assign status  = {4'b0000, ovr_q, ferr_q, rda_q, tbr_q};
   assign rdata   = bus.ioaddr[0] ? status : rx_buf;
   assign databus = drive ? rdata : 8'bzzzz_zzzz;
   assign bus.rda = rda_q;
   assign bus.tbr = tbr_q;

   // Baud generator: carry out of the phase accumulator is the 16x tick
   assign acc_sum = {1'b0, acc} + {{(ACC_W-15){1'b0}}, db};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db   <= 16'h0000;
         acc  <= '0;
         tick <= 1'b0;
      end else begin
         acc  <= acc_sum[ACC_W-1:0];
         tick <= acc_sum[ACC_W];
         if (bus.iocs && bus.ioaddr[1]) begin
            if (bus.ioaddr[0]) db[15:8] <= databus;
            else               db[7:0]  <= databus;
         end
      end
   end

   // TX buffer: tbr doubles as the buffer-empty flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_buf <= 8'h00;
         tbr_q  <= 1'b1;
      end else if (tx_take) begin
         tbr_q  <= 1'b1;
      end else if (wr_data && tbr_q) begin
         tx_buf <= databus;
         tbr_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= 4'd0;
         tx_bit   <= 3'd0;
         tx_sh    <= 8'h00;
         txd      <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_sh    <= tx_sh_n;
         txd      <= txd_n;
      end
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_bit_n   = tx_bit;
      tx_sh_n    = tx_sh;
      txd_n      = txd;
      tx_take    = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (!tbr_q) begin
               tx_take    = 1'b1;
               tx_state_n = TX_START;
               tx_sh_n    = tx_buf;
               tx_cnt_n   = 4'd0;
               txd_n      = 1'b0;
            end
         end
         TX_START: begin
            if (tick) begin
               if (tx_cnt == 4'd15) begin
                  tx_state_n = TX_DATA;
                  tx_cnt_n   = 4'd0;
                  tx_bit_n   = 3'd0;
                  txd_n      = tx_sh[0];
               end else begin
                  tx_cnt_n = tx_cnt + 4'd1;
               end
            end
         end
         TX_DATA: begin
            if (tick) begin
               if (tx_cnt == 4'd15) begin
                  tx_cnt_n = 4'd0;
                  if (tx_bit == 3'd7) begin
                     tx_state_n = TX_STOP;
                     txd_n      = 1'b1;
                  end else begin
                     tx_bit_n = tx_bit + 3'd1;
                     tx_sh_n  = {1'b0, tx_sh[7:1]};
                     txd_n    = tx_sh[1];
                  end
               end else begin
                  tx_cnt_n = tx_cnt + 4'd1;
               end
            end
         end
         TX_STOP: begin
            if (tick) begin
               if (tx_cnt == 4'd15) begin
                  tx_cnt_n = 4'd0;
                  // A waiting byte starts immediately so frames abut
                  if (!tbr_q) begin
                     tx_take    = 1'b1;
                     tx_state_n = TX_START;
                     tx_sh_n    = tx_buf;
                     txd_n      = 1'b0;
                  end else begin
                     tx_state_n = TX_IDLE;
                  end
               end else begin
                  tx_cnt_n = tx_cnt + 4'd1;
               end
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase
   end

   // RX synchroniser and state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1    <= 1'b1;
         rxs      <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= 4'd0;
         rx_bit   <= 3'd0;
         rx_sh    <= 8'h00;
      end else begin
         rx_s1    <= rxd;
         rxs      <= rx_s1;
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_sh    <= rx_sh_n;
      end
   end

   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_bit_n   = rx_bit;
      rx_sh_n    = rx_sh;
      rx_ok      = 1'b0;
      rx_bad     = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (tick && !rxs) begin
               rx_state_n = RX_START;
               rx_cnt_n   = 4'd0;
            end
         end
         RX_START: begin
            // Mid start bit: a line back high means a glitch, not a frame
            if (tick) begin
               if (rx_cnt == 4'd7) begin
                  rx_cnt_n   = 4'd0;
                  rx_bit_n   = 3'd0;
                  rx_state_n = rxs ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_n = rx_cnt + 4'd1;
               end
            end
         end
         RX_DATA: begin
            if (tick) begin
               if (rx_cnt == 4'd15) begin
                  rx_cnt_n = 4'd0;
                  rx_sh_n  = {rxs, rx_sh[7:1]};
                  if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                  else                rx_bit_n   = rx_bit + 3'd1;
               end else begin
                  rx_cnt_n = rx_cnt + 4'd1;
               end
            end
         end
         RX_STOP: begin
            if (tick) begin
               if (rx_cnt == 4'd15) begin
                  rx_cnt_n   = 4'd0;
                  rx_state_n = RX_IDLE;
                  rx_ok      = rxs;
                  rx_bad     = ~rxs;
               end else begin
                  rx_cnt_n = rx_cnt + 4'd1;
               end
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   // Receive buffer and flags: a new event wins over a same-edge clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_buf <= 8'h00;
         rda_q  <= 1'b0;
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         if (rx_ok)        rx_buf <= rx_sh;
         if (rx_ok)        rda_q  <= 1'b1;
         else if (rd_data) rda_q  <= 1'b0;
         if (rx_bad)       ferr_q <= 1'b1;
         else if (rd_stat) ferr_q <= 1'b0;
         if (rx_ok && rda_q && !rd_data) ovr_q <= 1'b1;
         else if (rd_stat)               ovr_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spart.sv
// Self-checking bench for spart (ACC_W=16, DB=0x8000 -> 32 clk per bit),
// compared against frame/flag expectations computed from the serial format.
module tb_spart;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spart_if bus();
   wire  [7:0] databus;
   logic [7:0] drv_data;
   logic       drv_en;
   assign databus = drv_en ? drv_data : 8'bzzzz_zzzz;

   wire  txd;
   wire  rxd;
   logic rxd_drv;
   logic loop;
   assign rxd = loop ? txd : rxd_drv;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   spart #(.ACC_W(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .databus (databus),
      .txd     (txd),
      .rxd     (rxd)
   );

   // Serial line level of slot k of an 8N1 frame carrying d
   function automatic logic frame_bit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return 1'((d >> (k - 1)) & 8'd1);
   endfunction

   function automatic logic [7:0] status_of(input int ovr, input int ferr, input int rda, input int tbr);
      return 8'(8 * ovr + 4 * ferr + 2 * rda + tbr);
   endfunction

   task automatic idle_bus();
      bus.iocs   = 1'b0;
      bus.iorw   = 1'b0;
      bus.ioaddr = 2'b00;
      drv_en     = 1'b0;
      drv_data   = 8'h00;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a;
      drv_en = 1'b1; drv_data = d;
      @(negedge clk);
      idle_bus();
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a; drv_en = 1'b0;
      #1 d = databus;
      @(negedge clk);
      idle_bus();
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_ok);
      for (int k = 0; k < 9; k++) begin
         rxd_drv = frame_bit(d, k);
         repeat (32) @(negedge clk);
      end
      if (stop_ok) begin
         rxd_drv = 1'b1;
         repeat (32) @(negedge clk);
      end else begin
         rxd_drv = 1'b0;
         repeat (24) @(negedge clk);
         rxd_drv = 1'b1;
         repeat (8) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [7:0] rv;
      idle_bus();
      loop = 1'b0; rxd_drv = 1'b1; rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.tbr !== 1'b1) begin n_fail++; $display("FAIL reset_tbr: got %b want 1", bus.tbr); end
      n_checks++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL reset_rda: got %b want 0", bus.rda); end
      n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
      rst = 1'b0;
      bus_read(2'b01, rv);
      n_checks++; if (rv !== status_of(0, 0, 0, 1)) begin n_fail++; $display("FAIL reset_status: got %h want %h", rv, status_of(0, 0, 0, 1)); end
      bus_read(2'b00, rv);
      n_checks++; if (rv !== 8'h00) begin n_fail++; $display("FAIL reset_rxbuf: got %h want 00", rv); end
   endtask

   task automatic test_divisor();
      int t0, len;
      @(negedge clk);
      bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = 2'b10; drv_en = 1'b1; drv_data = 8'h00;
      #1;
      n_checks++; if (databus !== 8'h00) begin n_fail++; $display("FAIL div_lo_bus: got %h want 00", databus); end
      @(negedge clk);
      bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'b11; drv_en = 1'b1; drv_data = 8'h80;
      #1;
      n_checks++; if (databus !== 8'h80) begin n_fail++; $display("FAIL div_hi_bus: got %h want 80", databus); end
      @(negedge clk);
      idle_bus();
      // Start bit of an all-ones byte shows one bit time directly
      bus_write(2'b00, 8'hFF);
      @(negedge clk);
      t0 = cyc; len = 0;
      while (txd === 1'b0 && len < 100) begin @(negedge clk); len++; end
      n_checks++; if (len < 30 || len > 33) begin n_fail++; $display("FAIL div_bit_time: got %0d clk want 30..33", len); end
      wait_cyc(t0 + 330);
   endtask

   task automatic test_tx_single(input logic [7:0] d);
      int t0;
      bus_write(2'b00, d);
      n_checks++; if (bus.tbr !== 1'b0) begin n_fail++; $display("FAIL tx_tbr_low: got %b want 0", bus.tbr); end
      @(negedge clk);
      t0 = cyc;
      n_checks++; if (bus.tbr !== 1'b1) begin n_fail++; $display("FAIL tx_tbr_back: got %b want 1", bus.tbr); end
      for (int k = 0; k < 10; k++) begin
         wait_cyc(t0 + 32 * k + 16);
         n_checks++;
         if (txd !== frame_bit(d, k)) begin
            n_fail++; $display("FAIL tx_bit%0d data %h: got %b want %b", k, d, txd, frame_bit(d, k));
         end
      end
      wait_cyc(t0 + 336);
      n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL tx_idle: got %b want 1", txd); end
   endtask

   task automatic test_back_to_back();
      int t0;
      logic [7:0] d1, d2;
      logic exp;
      d1 = 8'h55; d2 = 8'hC3;
      bus_write(2'b00, d1);
      @(negedge clk);
      t0 = cyc;
      bus_write(2'b00, d2);
      n_checks++; if (bus.tbr !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %b want 0", bus.tbr); end
      bus_write(2'b00, 8'h99);
      n_checks++; if (bus.tbr !== 1'b0) begin n_fail++; $display("FAIL b2b_ignored_tbr: got %b want 0", bus.tbr); end
      for (int k = 0; k < 20; k++) begin
         wait_cyc(t0 + 32 * k + 16);
         exp = (k < 10) ? frame_bit(d1, k) : frame_bit(d2, k - 10);
         n_checks++;
         if (txd !== exp) begin n_fail++; $display("FAIL b2b_bit%0d: got %b want %b", k, txd, exp); end
      end
      wait_cyc(t0 + 32 * 22);
      n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL b2b_no_third: got %b want 1", txd); end
      n_checks++; if (bus.tbr !== 1'b1) begin n_fail++; $display("FAIL b2b_tbr_end: got %b want 1", bus.tbr); end
   endtask

   task automatic test_rx(input logic [7:0] d);
      int t0, lat;
      logic [7:0] rv;
      loop = 1'b1;
      bus_write(2'b00, d);
      @(negedge clk);
      t0 = cyc;
      for (int i = 0; i < 400; i++) begin
         if (bus.rda === 1'b1) break;
         @(negedge clk);
      end
      lat = cyc - t0;
      n_checks++; if (bus.rda !== 1'b1) begin n_fail++; $display("FAIL rx_rda_timeout: got %b want 1", bus.rda); end
      n_checks++; if (lat < 300 || lat > 316) begin n_fail++; $display("FAIL rx_latency: got %0d want 300..316", lat); end
      bus_read(2'b00, rv);
      n_checks++; if (rv !== d) begin n_fail++; $display("FAIL rx_data: got %h want %h", rv, d); end
      n_checks++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL rx_rda_clr: got %b want 0", bus.rda); end
      bus_read(2'b01, rv);
      n_checks++; if (rv !== status_of(0, 0, 0, 1)) begin n_fail++; $display("FAIL rx_status: got %h want %h", rv, status_of(0, 0, 0, 1)); end
      repeat (40) @(negedge clk);
      loop = 1'b0;
   endtask

   task automatic test_rx_errors();
      logic [7:0] rv, a, b, c, d;
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      d = c ^ 8'($urandom_range(1, 255));
      // Short glitch: rejected at the mid-start check
      rxd_drv = 1'b0;
      repeat (8) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (400) @(negedge clk);
      n_checks++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL glitch_rda: got %b want 0", bus.rda); end
      bus_read(2'b01, rv);
      n_checks++; if (rv !== status_of(0, 0, 0, 1)) begin n_fail++; $display("FAIL glitch_status: got %h want %h", rv, status_of(0, 0, 0, 1)); end
      // Good frame, then a framing error that must leave it intact
      send_frame(a, 1'b1);
      repeat (4) @(negedge clk);
      n_checks++; if (bus.rda !== 1'b1) begin n_fail++; $display("FAIL ferr_pre_rda: got %b want 1", bus.rda); end
      send_frame(b, 1'b0);
      repeat (60) @(negedge clk);
      n_checks++; if (bus.rda !== 1'b1) begin n_fail++; $display("FAIL ferr_rda_kept: got %b want 1", bus.rda); end
      bus_read(2'b01, rv);
      n_checks++; if (rv !== status_of(0, 1, 1, 1)) begin n_fail++; $display("FAIL ferr_status: got %h want %h", rv, status_of(0, 1, 1, 1)); end
      bus_read(2'b01, rv);
      n_checks++; if (rv !== status_of(0, 0, 1, 1)) begin n_fail++; $display("FAIL ferr_cleared: got %h want %h", rv, status_of(0, 0, 1, 1)); end
      bus_read(2'b00, rv);
      n_checks++; if (rv !== a) begin n_fail++; $display("FAIL ferr_data: got %h want %h", rv, a); end
      // Overrun: two frames unread, second byte wins
      send_frame(c, 1'b1);
      send_frame(d, 1'b1);
      repeat (4) @(negedge clk);
      bus_read(2'b01, rv);
      n_checks++; if (rv !== status_of(1, 0, 1, 1)) begin n_fail++; $display("FAIL ovr_status: got %h want %h", rv, status_of(1, 0, 1, 1)); end
      bus_read(2'b00, rv);
      n_checks++; if (rv !== d) begin n_fail++; $display("FAIL ovr_data: got %h want %h", rv, d); end
      bus_read(2'b01, rv);
      n_checks++; if (rv !== status_of(0, 0, 0, 1)) begin n_fail++; $display("FAIL ovr_cleared: got %h want %h", rv, status_of(0, 0, 0, 1)); end
   endtask

   task automatic test_reset_midframe();
      int t0, n;
      logic [7:0] rv;
      bus_write(2'b00, 8'($urandom));
      @(negedge clk);
      t0 = cyc;
      wait_cyc(t0 + 100);
      #2 rst = 1'b1;
      #1;
      n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL rstmid_txd: got %b want 1", txd); end
      n_checks++; if (bus.tbr !== 1'b1) begin n_fail++; $display("FAIL rstmid_tbr: got %b want 1", bus.tbr); end
      @(negedge clk);
      rst = 1'b0;
      // DB is back to zero: a transfer still happens but the frame stalls
      bus_write(2'b00, 8'($urandom) | 8'h01);
      @(negedge clk);
      n_checks++; if (txd !== 1'b0) begin n_fail++; $display("FAIL rstmid_start: got %b want 0", txd); end
      repeat (300) @(negedge clk);
      n_checks++; if (txd !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", txd); end
      bus_read(2'b01, rv);
      n_checks++; if (rv !== status_of(0, 0, 0, 1)) begin n_fail++; $display("FAIL rstmid_status: got %h want %h", rv, status_of(0, 0, 0, 1)); end
      bus_write(2'b10, 8'h00);
      bus_write(2'b11, 8'h80);
      n = 0;
      while (txd === 1'b0 && n < 100) begin @(negedge clk); n++; end
      n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL rstmid_resume: got %b want 1", txd); end
   endtask

   initial begin
      test_reset();
      test_divisor();
      test_tx_single(8'hA5);
      test_tx_single(8'($urandom));
      test_tx_single(8'($urandom));
      test_back_to_back();
      test_rx(8'h3C);
      test_rx(8'($urandom));
      test_rx_errors();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spart.md
# spart

Serial peripheral (SPART) that sits directly below the processor-side driver on the shared 8-bit I/O bus. Holds a programmable 16-bit baud divisor, a transmit buffer and a receive buffer. Serialises/deserialises 8N1 frames on `txd`/`rxd` using a 16x-oversampling fractional baud generator. Reports `tbr`/`rda` handshakes back to the driver.

## Interface
- `ACC_W`, 22: baud accumulator width in bits (≥16). Sample tick rate = f_clk·DB/2^ACC_W; bit time = 16 ticks.
- `clk` in 1: the single clock domain.
- `rst` in 1: reset, asynchronous and active-high.
- `iocs` in 1: chip select; bus cycle is valid only when 1.
- `iorw` in 1: 1 = read, 0 = write (ignored for divisor addresses).
- `ioaddr` in 2: 00 data, 01 status, 10 divisor low (DB[7:0]), 11 divisor high (DB[15:8]).
- `databus` inout 8: driven by spart only when `iocs=1`, `iorw=1`, `ioaddr[1]=0`; otherwise high-Z.
- `rda` out 1: receive data available.
- `tbr` out 1: transmit buffer ready (empty).
- `txd` out 1: serial out, idle high.
- `rxd` in 1: serial in, asynchronous to `clk`.

## Operation
- Divisor: when `iocs=1` and `ioaddr=10`/`11`, DB low/high byte loads from `databus` on the clock edge, whatever `iorw` is. DB resets to 0x0000; with DB=0 there are no ticks and TX/RX stall.
- Baud gen: each edge `{c, acc} <= acc + DB` (DB zero-extended to ACC_W). `tick <= c` (registered carry). `acc` is not cleared on a divisor write. A new DB takes effect on the next edge, including mid-frame.
- Read mux (combinational), active when driving:
  - `ioaddr=00`: RX buffer.
  - `ioaddr=01`: `{4'b0, ovr, ferr, rda, tbr}`.
- TX buffer: a write (`iocs=1`, `iorw=0`, `ioaddr=00`) with `tbr=1` loads the buffer and clears `tbr`. A write while `tbr=0` is ignored (buffer unchanged).
- TX shifter: states IDLE, START, DATA, STOP.
  - On any edge where the buffer is full and the shifter is IDLE: buffer → shift reg, `tbr`→1, `txd`→0 (START), tick count←0.
  - Each state lasts 16 ticks.
  - DATA sends bits 0..7, LSB first.
  - STOP drives `txd=1`, then returns to IDLE. A full buffer reloads on the edge the shifter returns to IDLE, so back-to-back frames have no idle gap.
- RX: `rxd` passes through a 2-flop synchroniser (`rxs`). States IDLE, START, DATA, STOP; all counting is on ticks.
  - IDLE→START on a tick with `rxs=0`, count←0.
  - START: on the 8th tick, `rxs=1` → false start, back to IDLE; otherwise → DATA.
  - DATA: sample every 16th tick, 8 samples, LSB first.
  - STOP: sample after 16 more ticks.
    - Stop=1: buffer ← byte, `rda`←1. If `rda` was already 1 (and not being cleared that cycle), `ovr`←1 and the new byte overwrites.
    - Stop=0: byte discarded, `ferr`←1.
  - Return to IDLE after the stop sample.
- Clears:
  - A read of `ioaddr=00` clears `rda` on that edge.
  - A read of `ioaddr=01` clears `ferr` and `ovr` on that edge.
  - If a byte completes on the same edge as an `00` read: `rda` stays 1, buffer takes the new byte, no `ovr`.
  - If `ferr`/`ovr` is set on the same edge as a status read: set wins.

## Timing
- Reset values:
  - Outputs: `tbr=1`, `rda=0`, `txd=1`, `databus`=Z.
  - Internal: DB=0, `acc=0`, `tick=0`, `ferr=ovr=0`, both FSMs IDLE, buffers 0x00, synchroniser flops 1.
- Reset mid-frame aborts both FSMs immediately (`txd`→1 asynchronously). The partial RX byte is lost.
- Data write at edge N: `tbr=0` during cycle N+1. If the shifter is IDLE, the transfer occurs at edge N+1 and `tbr=1` again from N+2.
- Reads are combinational: data valid in the same cycle `iocs`/`iorw`/`ioaddr` are applied. Side-effect clears happen at the closing edge.
- Frame = 160 ticks on `txd`; first start bit appears the edge after the transfer.
- RX latency: `rda` rises one edge after the stop-bit sample. That sample falls about 152 ticks after the start edge, plus 2–3 clk of synchroniser delay.

## Test plan
All scenarios use `ACC_W=16`.
- **Divisor/ticks:** write 0x00 @10, 0x80 @11 (DB=0x8000) → `tick` every 2nd clk; bit time 32 clk; `databus` never driven during these writes.
- **TX single:** write 0xA5 @00 → `tbr` low one cycle; `txd` = 0,1,0,1,0,0,1,0,1,1 at 32-clk intervals; then idle high.
- **TX back-to-back:** write 0x55; write 0xC3 once `tbr=1` again, during the first frame → second start bit immediately follows the first stop bit; a third write while `tbr=0` is ignored.
- **RX:** loop `txd`→`rxd`, send 0x3C → `rda`=1, read @00 returns 0x3C, `rda`=0 next cycle; status read = 0x01 afterwards.
- **RX errors:**
  - Drive `rxd` low for 8 clk only → no byte, no `ferr`.
  - Send a frame with stop=0 → `ferr`=1, `rda` unchanged; status read returns bit2=1, then 0.
  - Two frames without reading → `ovr`=1, data = second byte.
- **Reset mid-frame:** assert `rst` during TX DATA → `txd`=1 and `tbr`=1 immediately; after release DB=0 and no ticks until reprogrammed.
